// File: rtl/game_pkg.sv
// ============================================================================
//  Module : game_pkg
//  Brief  : Shared FSM state encoding for the game timer.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage : game_pkg

`default_nettype wire

// File: rtl/game_timer.sv
// ============================================================================
//  Module : game_timer
//  Brief  : Up/down game tick counter with stop-on-target scoring.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module game_timer
    import game_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int RESET_VAL = 2**WIDTH - 1,
    parameter bit WRAP      = 1'b1
) (
    input  logic             clk_4_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] target_i,
    output logic [WIDTH-1:0] count_o,
    output logic [1:0]       state_o,
    output logic             tc_o,
    output logic             hit_o
);

    localparam logic [WIDTH-1:0] c_max_val   = '1;
    localparam logic [WIDTH-1:0] c_reset_val = WIDTH'(RESET_VAL);

    state_e           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_hit;

    state_e           w_next_state;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_tc;
    logic             w_next_hit;
    logic             w_at_term;
    logic [WIDTH-1:0] w_step_val;

    always_ff @(posedge clk_4_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_count <= c_reset_val;
            r_tc    <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            r_tc    <= w_next_tc;
            r_hit   <= w_next_hit;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_next_tc    = 1'b0;
        w_next_hit   = r_hit;
        w_at_term    = dir_i ? (r_count == c_max_val) : (r_count == '0);
        w_step_val   = dir_i ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));

        case (r_state)
            ST_RUN: begin
                // Stop has priority over both start and a pending step.
                if (stop_i) begin
                    w_next_state = ST_HOLD;
                    w_next_hit   = (r_count == target_i);
                end else if (en_i) begin
                    if (w_at_term) begin
                        w_next_tc = 1'b1;
                        if (WRAP) begin
                            w_next_count = w_step_val;
                        end else begin
                            w_next_state = ST_DONE;
                        end
                    end else begin
                        w_next_count = w_step_val;
                    end
                end
            end
            default: begin
                if (start_i) begin
                    w_next_state = ST_RUN;
                    w_next_count = load_val_i;
                    w_next_hit   = 1'b0;
                end
            end
        endcase
    end

    assign count_o = r_count;
    assign state_o = r_state;
    assign tc_o    = r_tc;
    assign hit_o   = r_hit;

endmodule : game_timer

`default_nettype wire

// File: tb/tb_game_timer.sv
// ============================================================================
//  Module : tb_game_timer
//  Brief  : Directed checks of wrapping and saturating game_timer instances.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_game_timer;

    logic       clk_4;
    logic       rst_n;
    logic       en, start, stop, dir;
    logic [4:0] load_val, target;

    logic [4:0] w_count, s_count;
    logic [1:0] w_state, s_state;
    logic       w_tc, s_tc, w_hit, s_hit;

    int n_checks = 0;
    int n_errors = 0;

    game_timer #(.WIDTH(5), .WRAP(1'b1)) dut_wrap (
        .clk_4_i(clk_4), .rst_ni(rst_n), .en_i(en), .start_i(start), .stop_i(stop),
        .dir_i(dir), .load_val_i(load_val), .target_i(target),
        .count_o(w_count), .state_o(w_state), .tc_o(w_tc), .hit_o(w_hit)
    );

    game_timer #(.WIDTH(5), .WRAP(1'b0)) dut_sat (
        .clk_4_i(clk_4), .rst_ni(rst_n), .en_i(en), .start_i(start), .stop_i(stop),
        .dir_i(dir), .load_val_i(load_val), .target_i(target),
        .count_o(s_count), .state_o(s_state), .tc_o(s_tc), .hit_o(s_hit)
    );

    initial clk_4 = 1'b0;
    always #5 clk_4 = ~clk_4;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk_4);
        @(negedge clk_4);
    endtask

    initial begin
        int wrap_cnt[5] = '{2, 1, 0, 31, 30};
        int wrap_tc[5]  = '{0, 0, 0, 1, 0};
        int up_en[4]    = '{1, 0, 1, 1};
        int up_cnt[4]   = '{31, 31, 0, 1};
        int up_tc[4]    = '{0, 0, 1, 0};

        rst_n = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0;
        load_val = 5'd0; target = 5'd0;
        @(negedge clk_4);
        tick(); tick();
        check("rst_count", 32'(w_count), 31);
        check("rst_state", 32'(w_state), 0);
        check("rst_tc", 32'(w_tc), 0);
        check("rst_hit", 32'(w_hit), 0);
        check("rst_count_sat", 32'(s_count), 31);

        // stop is ignored in IDLE
        rst_n = 1'b1; stop = 1'b1;
        tick();
        check("idle_stop_state", 32'(w_state), 0);
        check("idle_stop_count", 32'(w_count), 31);
        stop = 1'b0;

        // Down-count with wrap from 0 to 31
        load_val = 5'd3; dir = 1'b0; en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("start_count", 32'(w_count), 3);
        check("start_state", 32'(w_state), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("down_count%0d", i), 32'(w_count), 32'(wrap_cnt[i]));
            check($sformatf("down_tc%0d", i), 32'(w_tc), 32'(wrap_tc[i]));
        end
        // start is ignored in RUN: the count keeps stepping instead of reloading
        start = 1'b1;
        tick();
        check("run_start_ignored", 32'(w_count), 29);
        check("run_start_state", 32'(w_state), 1);
        start = 1'b0;

        // Park both instances, then exercise saturation on the non-wrapping one
        en = 1'b0; stop = 1'b1;
        tick();
        check("hold_state", 32'(w_state), 2);
        stop = 1'b0;
        load_val = 5'd1; start = 1'b1;
        tick();
        start = 1'b0; en = 1'b1;
        check("sat_load", 32'(s_count), 1);
        tick();
        check("sat_count0", 32'(s_count), 0);
        check("sat_state_run", 32'(s_state), 1);
        tick();
        check("sat_count_hold0", 32'(s_count), 0);
        check("sat_state_done", 32'(s_state), 3);
        check("sat_tc_pulse", 32'(s_tc), 1);
        tick();
        check("sat_tc_clear", 32'(s_tc), 0);
        check("sat_count_frozen", 32'(s_count), 0);
        en = 1'b0; load_val = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("sat_restart_state", 32'(s_state), 1);
        check("sat_restart_count", 32'(s_count), 5);

        // Stop on target
        target = 5'd10; stop = 1'b1;
        tick();
        stop = 1'b0;
        load_val = 5'd12; start = 1'b1;
        tick();
        start = 1'b0; en = 1'b1;
        tick(); tick();
        check("pre_stop_count", 32'(w_count), 10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("hit_state", 32'(w_state), 2);
        check("hit_flag", 32'(w_hit), 1);
        check("hit_count", 32'(w_count), 10);
        tick();
        check("hold_frozen_count", 32'(w_count), 10);
        check("hold_frozen_hit", 32'(w_hit), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_hit_clear", 32'(w_hit), 0);
        check("restart_count", 32'(w_count), 12);
        tick(); tick(); tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("miss_count", 32'(w_count), 9);
        check("miss_hit", 32'(w_hit), 0);

        // start and stop together in RUN: stop wins
        load_val = 5'd7; start = 1'b1;
        tick();
        check("both_pre_count", 32'(w_count), 7);
        stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0; en = 1'b0;
        check("both_state", 32'(w_state), 2);
        check("both_count", 32'(w_count), 7);

        // Up-count with gated enable and wrap from 31 to 0
        dir = 1'b1; load_val = 5'd30; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en = up_en[i][0];
            tick();
            check($sformatf("up_count%0d", i), 32'(w_count), 32'(up_cnt[i]));
            check($sformatf("up_tc%0d", i), 32'(w_tc), 32'(up_tc[i]));
        end
        check("sat_up_state", 32'(s_state), 3);
        check("sat_up_count", 32'(s_count), 31);

        // Reset mid-RUN overrides everything
        en = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0; dir = 1'b0; load_val = 5'd12; start = 1'b1;
        tick();
        check("mid_run_count", 32'(w_count), 12);
        rst_n = 1'b0; en = 1'b1;
        tick();
        check("midrst_count", 32'(w_count), 31);
        check("midrst_state", 32'(w_state), 0);
        check("midrst_tc", 32'(w_tc), 0);
        check("midrst_hit", 32'(w_hit), 0);

        // Reset also clears a latched hit
        rst_n = 1'b1; en = 1'b0; load_val = 5'd4; target = 5'd4;
        tick();
        start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        check("hit_before_rst", 32'(w_hit), 1);
        rst_n = 1'b0;
        tick();
        check("hit_after_rst", 32'(w_hit), 0);
        check("state_after_rst", 32'(w_state), 0);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_game_timer

`default_nettype wire

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter WIDTH, default 5: counter width in bits (legal range 2..16).
REQ-002 Parameter RESET_VAL, default 2**WIDTH-1: count value loaded at reset.
REQ-003 Parameter WRAP, default 1: 1 = modular wrap at the terminal value; 0 = saturate at the terminal value and enter DONE.
REQ-004 clk_4_i  in  1  game tick clock; the only clock.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 en_i  in  1  count-step enable, sampled in RUN only.
REQ-007 start_i  in  1  start/restart request.
REQ-008 stop_i  in  1  player stop request.
REQ-009 dir_i  in  1  count direction: 0 = down, 1 = up.
REQ-010 load_val_i  in  WIDTH  count value loaded on start.
REQ-011 target_i  in  WIDTH  winning value compared on stop.
REQ-012 count_o  out  WIDTH  current count, registered.
REQ-013 state_o  out  2  current FSM state.
REQ-014 tc_o  out  1  terminal-count pulse, registered.
REQ-015 hit_o  out  1  stop landed on target, registered.

Function
REQ-016 FSM states: IDLE=00, RUN=01, HOLD=10, DONE=11; state_o SHALL equal the state register.
REQ-017 IDLE/HOLD/DONE with start_i=1 -> RUN next cycle; count loads load_val_i; hit_o clears to 0.
REQ-018 In IDLE, stop_i SHALL be ignored; in RUN, start_i SHALL be ignored.
REQ-019 RUN with stop_i=1 -> HOLD next cycle; count SHALL not step that cycle; hit_o <= (count_o == target_i).
REQ-020 When start_i and stop_i are both high in RUN, stop SHALL win.
REQ-021 RUN with en_i=1 and stop_i=0: count steps by 1 each cycle; dir_i=0 decrements, dir_i=1 increments; en_i=0 holds the count.
REQ-022 Terminal value: 0 when dir_i=0; 2**WIDTH-1 when dir_i=1.
REQ-023 WRAP=1: a step from the terminal value wraps modulo 2**WIDTH (0 -> max when down, max -> 0 when up).
REQ-024 WRAP=0: a step attempted at the terminal value keeps the count unchanged and moves the FSM to DONE next cycle.
REQ-025 tc_o SHALL pulse high for exactly one cycle, in the cycle after a step taken at the terminal value (wrap or saturation); it is 0 otherwise.
REQ-026 A dir_i change takes effect on the next step; there is no latency beyond one cycle.
REQ-027 HOLD and DONE SHALL freeze count_o and hit_o until start_i.

Reset
REQ-028 With rst_ni=0 at a clk_4_i edge: count_o=RESET_VAL, state_o=IDLE, tc_o=0, hit_o=0.
REQ-029 Reset SHALL override all other inputs in any state, including mid-RUN.

Structure
REQ-030 Package game_pkg SHALL hold the state enum (state_e) and its 2-bit encoding.
REQ-031 The block is a single module with no sub-module; the step/terminal detect is inline combinational logic feeding the count and tc_o registers.

Verification
REQ-032 Reset, then start_i with load_val_i=3 and dir_i=0, en_i=1 for 5 cycles -> count_o 3,2,1,0,31; tc_o high for one cycle after the 0->31 step.
REQ-033 WRAP=0 instance, load_val_i=1, dir_i=0, en_i=1 -> count_o 1,0,0; state_o=DONE; single tc_o pulse; start_i reloads and returns to RUN.
REQ-034 Running with target_i=10, assert stop_i when count_o=10 -> HOLD, hit_o=1, count_o stays 10; stop at 9 -> hit_o=0.
REQ-035 start_i and stop_i both high in RUN at count 7 -> HOLD with count_o=7.
REQ-036 dir_i=1, load_val_i=30, en_i toggling 1,0,1,1 -> count_o 31,31,0,1; one tc_o pulse.
REQ-037 rst_ni low mid-RUN at count 12 -> next cycle count_o=31, state_o=IDLE, tc_o=0, hit_o=0.
